// File: rtl/boot_copier_pkg.sv
// Boot copier shared types.
// State encoding and parameter legality checks.
package boot_copier_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WRITE,
    ST_FINISH
  } state_t;

  localparam int ROM_LAT_MIN = 1;
  localparam int ROM_LAT_MAX = 2;

  // The FETCH wait counter must hold 0..ROM_LATENCY.
  localparam int WAIT_W = 2;

  function automatic bit wait_fits(input int lat);
    return lat < (1 << WAIT_W);
  endfunction

  function automatic bit rom_latency_ok(input int lat);
    return (lat >= ROM_LAT_MIN) &&
           (lat <= ROM_LAT_MAX) &&
           wait_fits(lat);
  endfunction

  function automatic bit copy_len_ok(
    input int len,
    input int aw
  );
    return (len >= 1) &&
           (longint'(len) <= (longint'(1) << aw));
  endfunction

endpackage

// File: rtl/boot_copier.sv
// Boot-time shadow copier: ROM block to external RAM.
// Holds busy until every word is acknowledged.
module boot_copier
  import boot_copier_pkg::*;
#(
  parameter int DATA_WIDTH      = 8,
  parameter int ADDR_WIDTH      = 12,
  parameter int ROM_LATENCY     = 1,
  parameter int COPY_LEN        = 4096,
  parameter int DEST_ADDR_WIDTH = 16,
  parameter logic [DEST_ADDR_WIDTH-1:0] DEST_BASE = '0,
  parameter string AUTO_START   = "TRUE"
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  output logic [ADDR_WIDTH-1:0]      rom_address,
  input  logic [DATA_WIDTH-1:0]      rom_data,
  output logic [DEST_ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]      mem_wdata,
  output logic                       mem_wr_req,
  input  logic                       mem_wr_ack,
  output logic                       busy,
  output logic                       done
);

  localparam int IDX_W = ADDR_WIDTH + 1;
  localparam bit AUTO  = (AUTO_START == "TRUE");

  localparam logic [IDX_W-1:0] LAST_IDX =
    IDX_W'(COPY_LEN - 1);
  localparam logic [WAIT_W-1:0] LAST_WAIT =
    WAIT_W'(ROM_LATENCY);

  if (!rom_latency_ok(ROM_LATENCY) ||
      !copy_len_ok(COPY_LEN, ADDR_WIDTH)) begin : g_bad_param
    $error("boot_copier: illegal ROM_LATENCY or COPY_LEN");
  end

  state_t                     state_q, state_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [WAIT_W-1:0]          wait_q, wait_d;
  logic [ADDR_WIDTH-1:0]      rom_addr_q, rom_addr_d;
  logic [DEST_ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]      mem_wdata_q, mem_wdata_d;
  logic                       req_q, req_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic                       arm_q, arm_d;
  logic [IDX_W-1:0]           idx_inc;

  assign idx_inc = idx_q + IDX_W'(1);

  // Next-state and registered-output computation.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    wait_d      = wait_q;
    rom_addr_d  = rom_addr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    req_d       = req_q;
    busy_d      = busy_q;
    done_d      = done_q;
    // Auto-start fires only on the first edge after reset.
    arm_d       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start || arm_q) begin
          state_d    = ST_FETCH;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          idx_d      = '0;
          wait_d     = '0;
          rom_addr_d = '0;
        end
      end
      ST_FETCH: begin
        if (wait_q == LAST_WAIT) begin
          mem_wdata_d = rom_data;
          mem_addr_d  = DEST_BASE +
                        DEST_ADDR_WIDTH'(idx_q);
          req_d       = 1'b1;
          state_d     = ST_WRITE;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      ST_WRITE: begin
        if (mem_wr_ack) begin
          req_d = 1'b0;
          if (idx_q == LAST_IDX) begin
            state_d = ST_FINISH;
          end else begin
            idx_d      = idx_inc;
            rom_addr_d = idx_inc[ADDR_WIDTH-1:0];
            wait_d     = '0;
            state_d    = ST_FETCH;
          end
        end
      end
      ST_FINISH: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any copy.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      wait_q      <= '0;
      rom_addr_q  <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      req_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      arm_q       <= AUTO;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      wait_q      <= wait_d;
      rom_addr_q  <= rom_addr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      req_q       <= req_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      arm_q       <= arm_d;
    end
  end

  assign rom_address = rom_addr_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_wr_req  = req_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule
